// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock programmable FIFO: width math and read-mode encodings.
package sync_fifo_pkg;

  localparam int RD_REGISTERED = 0;
  localparam int RD_SHOWAHEAD  = 1;

  // Never returns less than 1 so a depth-1/2 pointer still has a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read address, no reset.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, any depth; flags/usedw from registered count; show-ahead 1-cycle, registered 2-cycle write-to-data.
// Writes refused when full, reads when empty; SYNC_FIFO_ERR_EN adds sticky overflow/underflow ports.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 140,
  parameter int FIFO_DEPTH = 6,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int SHOWAHEAD  = RD_REGISTERED,
  localparam int CNT_W     = cnt_w(FIFO_DEPTH),
  localparam int PTR_W     = ptr_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wren,
  input  logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  rden,
  output logic [FIFO_WIDTH-1:0] rddata,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      usedw
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_ram_rd;

  if (AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_prog: AF_LEVEL must not exceed FIFO_DEPTH");
  end
  if (AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
    $error("sync_fifo_prog: AE_LEVEL must be below FIFO_DEPTH");
  end

  assign empty        = (r_count == '0);
  assign full         = (r_count == CNT_W'(FIFO_DEPTH));
  assign almost_empty = (int'(r_count) <= AE_LEVEL);
  assign almost_full  = (int'(r_count) >= AF_LEVEL);
  assign usedw        = r_count;

  assign w_wr_acc = wren & ~full;
  assign w_rd_acc = rden & ~empty;

  // Non-power-of-two depth: wrap explicitly rather than relying on overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - CNT_W'(1);
    end
  end

  sync_fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_acc & ~rst),
    .waddr (r_wr_ptr),
    .wdata (wrdata),
    .raddr (r_rd_ptr),
    .rdata (w_ram_rd)
  );

  if (SHOWAHEAD == RD_SHOWAHEAD) begin : g_showahead
    assign rddata = empty ? '0 : w_ram_rd;
  end else begin : g_registered
    logic [FIFO_WIDTH-1:0] r_rddata;
    always_ff @(posedge clk) begin
      if (rst)           r_rddata <= '0;
      else if (w_rd_acc) r_rddata <= w_ram_rd;
    end
    assign rddata = r_rddata;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wren & full);
      r_underflow <= r_underflow | (rden & empty);
    end
  end
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: registered and show-ahead instances share one stimulus stream and one queue model.
module tb_sync_fifo_prog;

  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic [W-1:0]  wrdata = '0;

  logic [W-1:0]  ra_rddata, sa_rddata;
  logic          ra_empty, ra_full, ra_ae, ra_af;
  logic          sa_empty, sa_full, sa_ae, sa_af;
  logic [CW-1:0] ra_usedw, sa_usedw;
`ifdef SYNC_FIFO_ERR_EN
  logic          ra_ovf, ra_udf, sa_ovf, sa_udf;
  logic          m_ovf, m_udf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(0)
  ) u_reg (
    .clk(clk), .rst(rst), .wren(wren), .wrdata(wrdata), .rden(rden),
    .rddata(ra_rddata), .empty(ra_empty), .full(ra_full),
    .almost_empty(ra_ae), .almost_full(ra_af), .usedw(ra_usedw)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(ra_ovf), .underflow(ra_udf)
`endif
  );

  sync_fifo_prog #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1)
  ) u_sa (
    .clk(clk), .rst(rst), .wren(wren), .wrdata(wrdata), .rden(rden),
    .rddata(sa_rddata), .empty(sa_empty), .full(sa_full),
    .almost_empty(sa_ae), .almost_full(sa_af), .usedw(sa_usedw)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(sa_ovf), .underflow(sa_udf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("reg_rddata",  32'(ra_rddata), 32'(m_rd));
    chk("sa_rddata",   32'(sa_rddata), (n != 0) ? 32'(q[0]) : 32'd0);
    chk("reg_usedw",   32'(ra_usedw),  32'(n));
    chk("sa_usedw",    32'(sa_usedw),  32'(n));
    chk("reg_empty",   32'(ra_empty),  32'(n == 0));
    chk("sa_empty",    32'(sa_empty),  32'(n == 0));
    chk("reg_full",    32'(ra_full),   32'(n == DEPTH));
    chk("sa_full",     32'(sa_full),   32'(n == DEPTH));
    chk("reg_aempty",  32'(ra_ae),     32'(n <= AE));
    chk("sa_aempty",   32'(sa_ae),     32'(n <= AE));
    chk("reg_afull",   32'(ra_af),     32'(n >= AF));
    chk("sa_afull",    32'(sa_af),     32'(n >= AF));
`ifdef SYNC_FIFO_ERR_EN
    chk("reg_ovf", 32'(ra_ovf), 32'(m_ovf));
    chk("sa_ovf",  32'(sa_ovf), 32'(m_ovf));
    chk("reg_udf", 32'(ra_udf), 32'(m_udf));
    chk("sa_udf",  32'(sa_udf), 32'(m_udf));
`endif
  endtask

  // One clock of stimulus; the model updates after the edge, pop before push.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic rd);
    logic wacc, racc;
    @(negedge clk);
    wren = wr; wrdata = d; rden = rd;
    wacc = wr && (q.size() != DEPTH);
    racc = rd && (q.size() != 0);
`ifdef SYNC_FIFO_ERR_EN
    if (wr && q.size() == DEPTH) m_ovf = 1'b1;
    if (rd && q.size() == 0)     m_udf = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (racc) m_rd = q.pop_front();
    if (wacc) q.push_back(d);
    wren = 1'b0; rden = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wren = 1'b0; rden = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_rd = '0;
`ifdef SYNC_FIFO_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] d;
    int           u;
    logic         af;
    logic         ae;
    logic         f;
    logic         e;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Fill 0x01..0x06 then 7 reads; expected flags with AF=4, AE=1, DEPTH=6.
    tbl[0]  = '{1'b1, 1'b0, 8'h01, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h04, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h05, 5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h06, 6, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};

    m_rd = '0;
`ifdef SYNC_FIFO_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk("tbl_usedw", 32'(ra_usedw), 32'(tbl[i].u));
      chk("tbl_afull", 32'(ra_af),    32'(tbl[i].af));
      chk("tbl_aempty",32'(ra_ae),    32'(tbl[i].ae));
      chk("tbl_full",  32'(ra_full),  32'(tbl[i].f));
      chk("tbl_empty", 32'(ra_empty), 32'(tbl[i].e));
      if (i >= 6) chk("tbl_rddata", 32'(ra_rddata), (i == 12) ? 32'h06 : 32'(i - 5));
    end

    // Overflow: writes of 0xAA while full must not land in memory.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_usedw", 32'(ra_usedw), 32'd6);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("ovf_drain_data", 32'(ra_rddata), 32'h10 + 32'(i));
    end

    // Simultaneous read/write at usedw=3, long enough to wrap both pointers.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h30 + 8'(i), 1'b1);
      chk("simul_usedw", 32'(ra_usedw), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("simul_last", 32'(ra_rddata), 32'h39);

    // Read+write while empty: write wins, read rejected, rddata held.
    step(1'b1, 8'h77, 1'b1);
    chk("empty_rw_usedw",  32'(ra_usedw),  32'd1);
    chk("empty_rw_rddata", 32'(ra_rddata), 32'h39);
    chk("empty_rw_sa",     32'(sa_rddata), 32'h77);
    step(1'b0, 8'h00, 1'b1);

    // Show-ahead: word visible without rden, cleared once acknowledged.
    step(1'b1, 8'h55, 1'b0);
    chk("sa_visible", 32'(sa_rddata), 32'h55);
    step(1'b0, 8'h00, 1'b0);
    chk("sa_hold", 32'(sa_rddata), 32'h55);
    step(1'b0, 8'h00, 1'b1);
    chk("sa_after_rd", 32'(sa_rddata), 32'h00);
    chk("sa_after_rd_empty", 32'(sa_empty), 32'd1);

    // Reset mid-operation with four entries stored.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h41 + 8'(i), 1'b0);
    chk("pre_rst_usedw", 32'(ra_usedw), 32'd4);
`ifdef SYNC_FIFO_ERR_EN
    chk("pre_rst_ovf", 32'(ra_ovf), 32'd1);
`endif
    do_reset();
    chk("rst_usedw",  32'(ra_usedw),  32'd0);
    chk("rst_empty",  32'(ra_empty),  32'd1);
    chk("rst_rddata", 32'(ra_rddata), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("rst_ovf", 32'(ra_ovf), 32'd0);
`endif
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_rd_usedw",  32'(ra_usedw),  32'd0);
    chk("post_rst_rd_rddata", 32'(ra_rddata), 32'd0);
    chk("post_rst_rd_sa",     32'(sa_rddata), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with arbitrary (non-power-of-two) depth, a full-width fill counter, programmable almost-full/almost-empty thresholds and a selectable read mode: registered read or show-ahead. It replaces dual-clock FIFO instances wherever producer and consumer share one clock, so no Gray-code pointer synchronisation is needed. It also fixes the one-bit-short fill count of earlier FIFOs.

## Interface
Parameters:
- FIFO_WIDTH, 140, data width in bits (≥1)
- FIFO_DEPTH, 6, number of entries (≥2, any integer)
- AF_LEVEL, FIFO_DEPTH-1, almost_full asserts when usedw ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when usedw ≤ AE_LEVEL
- SHOWAHEAD, 0, 0 = registered read, 1 = show-ahead (first-word-fall-through)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- wren  input  1  write request
- wrdata  input  FIFO_WIDTH  write data
- rden  input  1  read request
- rddata  output  FIFO_WIDTH  read data
- empty  output  1  no entries stored
- full  output  1  FIFO_DEPTH entries stored
- almost_empty  output  1  usedw ≤ AE_LEVEL
- almost_full  output  1  usedw ≥ AF_LEVEL
- usedw  output  CNT_W  entries stored, where CNT_W = clog2(FIFO_DEPTH+1)
- overflow  output  1  sticky: a write was rejected (only with SYNC_FIFO_ERR_EN)
- underflow  output  1  sticky: a read was rejected (only with SYNC_FIFO_ERR_EN)

## Operation
- **Accepted write:** wr_acc = wren & ~full. The entry is stored at wr_ptr, and wr_ptr advances.
- **Accepted read:** rd_acc = rden & ~empty. rd_ptr advances.
- Both `full` and `empty` are sampled at the start of the cycle.
- **Pointers:** width clog2(FIFO_DEPTH). Each wraps from FIFO_DEPTH-1 to 0; no extra wrap bit.
- **Count register:**
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - usedw equals the count.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - almost_empty and almost_full are compared against the count.
  - All flags are therefore functions of registered state only.
- **Simultaneous wren & rden:**
  - Empty: write accepted, read rejected.
  - Full: read accepted, write rejected.
  - Otherwise: both accepted and the count is unchanged.
- **SHOWAHEAD=0:**
  - rddata is registered and loaded with mem[rd_ptr] on rd_acc.
  - rddata holds its value otherwise, including while empty.
- **SHOWAHEAD=1:**
  - rddata = mem[rd_ptr] while ~empty, else all-zero (combinational from RAM/pointer).
  - rden acknowledges the displayed word.
- **Reset:** pointers, count and rddata are cleared to 0. Memory contents are not cleared.
- **Output values under reset:** empty=1, full=0, usedw=0, overflow=0, underflow=0.
  - almost_empty=1 (AE_LEVEL ≥ 0).
  - almost_full=0 unless AF_LEVEL==0.
- **Reset mid-operation:** all stored entries are discarded; the next cycle behaves as after power-up.
- **Elaboration checks:** reject AF_LEVEL > FIFO_DEPTH and AE_LEVEL ≥ FIFO_DEPTH.

## Timing
- Write at edge N: empty falls and usedw increments after edge N.
- SHOWAHEAD=1: the word is visible on rddata in cycle N+1 (1-cycle write-to-read latency).
- SHOWAHEAD=0: rden in cycle N+1 is accepted at edge N+1; rddata is valid after edge N+1 (2 cycles from write).
- full rises after the edge of the FIFO_DEPTH-th net write.
- full falls after the edge of the first accepted read.
- No combinational path from wren or rden to any flag or to usedw.

## Configuration
- **SYNC_FIFO_ERR_EN defined:**
  - overflow is set at the edge where wren & full.
  - underflow is set at the edge where rden & empty.
  - Both hold until rst.
  - A rejected write never modifies memory; a rejected read never modifies rddata.
- **SYNC_FIFO_ERR_EN undefined:** the overflow and underflow ports are absent, and rejected requests are silently ignored.

## Structure
- **Package sync_fifo_pkg:**
  - clog2 function (returns ≥1).
  - CNT_W/PTR_W helper.
  - Read-mode localparams RD_REGISTERED=0 and RD_SHOWAHEAD=1.
- **Sub-module sync_fifo_ram:**
  - Simple dual-port array, FIFO_WIDTH × FIFO_DEPTH.
  - One synchronous write port and one asynchronous read address; no reset.
- **Top level:** pointers, count, flags and the rddata register.

## Test plan
- **Fill and drain, DEPTH=6, SHOWAHEAD=0:**
  - Stimulus: write 0x01..0x06, then 7 reads.
  - usedw counts 1..6; full asserts after the 6th write.
  - rddata returns 0x01..0x06, each one cycle after its rden.
  - The 7th read is rejected; underflow=1 with ERR_EN.
- **Overflow:**
  - Stimulus: while full, drive wren with data 0xAA.
  - usedw stays 6 and memory is unchanged (subsequent reads show no 0xAA).
  - overflow=1 with ERR_EN.
- **Simultaneous read/write:**
  - At usedw=3: rden & wren for 10 cycles. usedw stays 3, data order is preserved, and the pointers wrap past 5→0.
  - At empty: rden & wren. usedw becomes 1 and rddata is unchanged.
- **Thresholds (AF_LEVEL=4, AE_LEVEL=1):**
  - almost_full rises exactly when usedw becomes 4.
  - almost_empty falls exactly when usedw becomes 2.
- **Show-ahead (SHOWAHEAD=1):**
  - Stimulus: write 0x55 into the empty FIFO.
  - rddata=0x55 the next cycle with no rden.
  - After rden, rddata=0 and empty=1.
- **Reset mid-operation:**
  - Stimulus: assert rst with usedw=4 and overflow set.
  - Next cycle: usedw=0, empty=1, overflow=0, rddata=0.
  - A following read is rejected.
